// File: rtl/pocket_pkg.sv
// Shared video timing definitions.
// Provides the timing-set payload carried on the cfg port, the timing that
// is active out of reset, and the sanity check applied to offered timing
// sets before they are allowed to replace the active one.
package pocket_pkg;

  localparam int unsigned VT_H_W       = 10;
  localparam int unsigned VT_V_W       = 10;
  localparam int unsigned VT_MIN_TOTAL = 16;

  // One complete timing set; all comparisons are against pixel/line indices.
  typedef struct packed {
    logic [VT_H_W-1:0] h_total;
    logic [VT_H_W-1:0] h_de_start;
    logic [VT_H_W-1:0] h_de_end;
    logic [VT_H_W-1:0] hs_pos;
    logic [VT_V_W-1:0] v_total;
    logic [VT_V_W-1:0] v_de_start;
    logic [VT_V_W-1:0] v_de_end;
  } video_timing_t;

  // 512x512 raster with a 400x320 active window.
  localparam video_timing_t VT_DEFAULT = '{
    h_total:    VT_H_W'(512),
    h_de_start: VT_H_W'(50),
    h_de_end:   VT_H_W'(450),
    hs_pos:     VT_H_W'(10),
    v_total:    VT_V_W'(512),
    v_de_start: VT_V_W'(50),
    v_de_end:   VT_V_W'(370)
  };

  // Rasters smaller than VT_MIN_TOTAL on either axis are rejected.
  function automatic logic timing_ok(input video_timing_t t);
    return (32'(t.h_total) >= VT_MIN_TOTAL) && (32'(t.v_total) >= VT_MIN_TOTAL);
  endfunction

endpackage

// File: rtl/video_xy_counter.sv
// Raster position counter.
// Holds the current pixel column/line and computes the position for the
// next cycle. When run is low the position is forced to the origin.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   run                advance the raster this cycle
//   h_total, v_total   active raster size
//   x, y               registered current position
//   x_nxt_c, y_nxt_c   position that will be presented next cycle
//   last_c             current position is the last pixel of the frame
module video_xy_counter
#(
  parameter int unsigned H_W = 10,
  parameter int unsigned V_W = 10
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           run,
  input  logic [H_W-1:0] h_total,
  input  logic [V_W-1:0] v_total,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic [H_W-1:0] x_nxt_c,
  output logic [V_W-1:0] y_nxt_c,
  output logic           last_c
);

  logic x_end_c;
  logic y_end_c;

  // >= rather than == so an out-of-range position can never run away.
  assign x_end_c = (x >= (h_total - H_W'(1)));
  assign y_end_c = (y >= (v_total - V_W'(1)));
  assign last_c  = run && x_end_c && y_end_c;

  // Next position: advance along the line, wrap to the next line, wrap frame.
  always_comb begin
    x_nxt_c = '0;
    y_nxt_c = '0;
    if (run) begin
      if (x_end_c) begin
        if (!y_end_c) begin
          y_nxt_c = y + V_W'(1);
        end
      end else begin
        x_nxt_c = x + H_W'(1);
        y_nxt_c = y;
      end
    end
  end

  // Position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else begin
      x <= x_nxt_c;
      y <= y_nxt_c;
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// Video timing generator with frame-synchronous reconfiguration.
// Generates x/y raster position and de/hs/vs strobes from an active timing
// set. New timing sets are taken through a valid/ready handshake into a
// pending slot and swapped in only at a frame boundary (or immediately when
// stopped), so a frame is never produced with mixed timing.
// Ports:
//   video_rgb_clock, reset_n   pixel clock, async active-low reset
//   enable                     run request; a drop takes effect at frame end
//   cfg_valid, cfg_ready, cfg  timing set handshake
//   x, y                       current pixel column / line
//   video_de/hs/vs/skip        strobes aligned with x/y
//   cfg_applied, cfg_error     one-cycle pulses: pending set applied/discarded
module video_timing_ctrl
  import pocket_pkg::*;
#(
  parameter int unsigned H_W = 10,
  parameter int unsigned V_W = 10
) (
  input  logic           video_rgb_clock,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  video_timing_t  cfg,
  output logic [H_W-1:0] x,
  output logic [V_W-1:0] y,
  output logic           video_de,
  output logic           video_hs,
  output logic           video_vs,
  output logic           video_skip,
  output logic           cfg_applied,
  output logic           cfg_error
);

  localparam logic [0:0] ST_STOPPED = 1'b0;
  localparam logic [0:0] ST_RUN     = 1'b1;

  logic [0:0]     state_q;
  logic [0:0]     state_d;
  video_timing_t  act_q;
  video_timing_t  act_d;
  video_timing_t  pend_q;
  video_timing_t  pend_d;
  logic           pend_vld_q;
  logic           pend_vld_d;
  logic           ready_d;
  logic           applied_d;
  logic           error_d;
  logic           de_d;
  logic           hs_d;
  logic           vs_d;
  logic           accept_c;
  logic           run_c;
  logic           run_nxt_c;
  logic           last_c;
  logic [H_W-1:0] x_nxt_c;
  logic [V_W-1:0] y_nxt_c;

  assign run_c      = (state_q == ST_RUN);
  assign video_skip = 1'b0;

  // Raster position driven from the currently active timing set.
  video_xy_counter #(
    .H_W (H_W),
    .V_W (V_W)
  ) u_xy (
    .clk     (video_rgb_clock),
    .rst_n   (reset_n),
    .run     (run_c),
    .h_total (H_W'(act_q.h_total)),
    .v_total (V_W'(act_q.v_total)),
    .x       (x),
    .y       (y),
    .x_nxt_c (x_nxt_c),
    .y_nxt_c (y_nxt_c),
    .last_c  (last_c)
  );

  // State register.
  always_ff @(posedge video_rgb_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, config handling and next-cycle strobes.
  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    applied_d  = 1'b0;
    error_d    = 1'b0;
    accept_c   = cfg_valid && cfg_ready;

    case (state_q)
      ST_STOPPED: begin
        if (enable) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Stopping is only allowed once the frame is complete.
        if (last_c && !enable) begin
          state_d = ST_STOPPED;
        end
      end
      default: begin
        state_d = ST_STOPPED;
      end
    endcase

    // A pending set is validated one cycle after acceptance. A good set
    // waits for the frame boundary unless the raster is idle.
    if (pend_vld_q) begin
      if (!timing_ok(pend_q)) begin
        pend_vld_d = 1'b0;
        error_d    = 1'b1;
      end else if (!run_c || last_c) begin
        act_d      = pend_q;
        pend_vld_d = 1'b0;
        applied_d  = 1'b1;
      end
    end

    // cfg_ready is low whenever a set is pending, so accept never collides
    // with the pending-slot update above.
    if (accept_c) begin
      pend_d     = cfg;
      pend_vld_d = 1'b1;
    end

    ready_d = !pend_vld_d;

    // Strobes are computed for the position and timing of the next cycle so
    // the registered outputs line up with the registered x/y.
    run_nxt_c = (state_d == ST_RUN);
    vs_d = run_nxt_c && (x_nxt_c == '0) && (y_nxt_c == '0);
    hs_d = run_nxt_c && (x_nxt_c == H_W'(act_d.hs_pos));
    de_d = run_nxt_c
        && (x_nxt_c >= H_W'(act_d.h_de_start)) && (x_nxt_c < H_W'(act_d.h_de_end))
        && (y_nxt_c >= V_W'(act_d.v_de_start)) && (y_nxt_c < V_W'(act_d.v_de_end));
  end

  // Config registers and registered outputs.
  always_ff @(posedge video_rgb_clock or negedge reset_n) begin
    if (!reset_n) begin
      act_q       <= VT_DEFAULT;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      cfg_ready   <= 1'b0;
      cfg_applied <= 1'b0;
      cfg_error   <= 1'b0;
      video_de    <= 1'b0;
      video_hs    <= 1'b0;
      video_vs    <= 1'b0;
    end else begin
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      cfg_ready   <= ready_d;
      cfg_applied <= applied_d;
      cfg_error   <= error_d;
      video_de    <= de_d;
      video_hs    <= hs_d;
      video_vs    <= vs_d;
    end
  end

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Self-checking bench for video_timing_ctrl.
// The driver steps a raster-level reference model on every clock and queues
// the expected port values; the monitor pops and compares each cycle.
module tb_video_timing_ctrl;
  import pocket_pkg::*;

  localparam int unsigned H_W = 10;
  localparam int unsigned V_W = 10;
  localparam int MAX_FAILS = 40;

  logic           video_rgb_clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           enable = 1'b0;
  logic           cfg_valid = 1'b0;
  logic           cfg_ready;
  video_timing_t  cfg = '0;
  logic [H_W-1:0] x;
  logic [V_W-1:0] y;
  logic           video_de;
  logic           video_hs;
  logic           video_vs;
  logic           video_skip;
  logic           cfg_applied;
  logic           cfg_error;

  always #5 video_rgb_clock = ~video_rgb_clock;

  video_timing_ctrl #(
    .H_W (H_W),
    .V_W (V_W)
  ) dut (
    .video_rgb_clock (video_rgb_clock),
    .reset_n         (reset_n),
    .enable          (enable),
    .cfg_valid       (cfg_valid),
    .cfg_ready       (cfg_ready),
    .cfg             (cfg),
    .x               (x),
    .y               (y),
    .video_de        (video_de),
    .video_hs        (video_hs),
    .video_vs        (video_vs),
    .video_skip      (video_skip),
    .cfg_applied     (cfg_applied),
    .cfg_error       (cfg_error)
  );

  typedef struct packed {
    logic [H_W-1:0] x;
    logic [V_W-1:0] y;
    logic de;
    logic hs;
    logic vs;
    logic skip;
    logic ready;
    logic applied;
    logic error;
  } obs_t;

  typedef struct {
    int ht, hds, hde, hs, vt, vds, vde;
  } mcfg_t;

  obs_t  exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    seen_de = 1'b0;
  int    fde_x = 0;
  int    fde_y = 0;

  // Reference model: raster position plus config bookkeeping.
  mcfg_t m_act;
  mcfg_t m_pend;
  bit    m_run, m_pendv, m_ready, m_applied, m_error;
  int    mx, my;

  function automatic mcfg_t to_m(video_timing_t c);
    mcfg_t m;
    m.ht  = 32'(c.h_total);
    m.hds = 32'(c.h_de_start);
    m.hde = 32'(c.h_de_end);
    m.hs  = 32'(c.hs_pos);
    m.vt  = 32'(c.v_total);
    m.vds = 32'(c.v_de_start);
    m.vde = 32'(c.v_de_end);
    return m;
  endfunction

  function automatic video_timing_t mk(int ht, int hds, int hde, int hs, int vt, int vds, int vde);
    video_timing_t c;
    c.h_total    = H_W'(ht);
    c.h_de_start = H_W'(hds);
    c.h_de_end   = H_W'(hde);
    c.hs_pos     = H_W'(hs);
    c.v_total    = V_W'(vt);
    c.v_de_start = V_W'(vds);
    c.v_de_end   = V_W'(vde);
    return c;
  endfunction

  function automatic video_timing_t rand_cfg();
    return mk($urandom_range(12, 40), $urandom_range(0, 42), $urandom_range(0, 42),
              $urandom_range(0, 42), $urandom_range(12, 30), $urandom_range(0, 32),
              $urandom_range(0, 32));
  endfunction

  task automatic model_reset();
    m_run = 1'b0; mx = 0; my = 0;
    m_act = to_m(VT_DEFAULT);
    m_pendv = 1'b0; m_ready = 1'b0; m_applied = 1'b0; m_error = 1'b0;
  endtask

  // One clock edge of the reference model.
  task automatic model_step(bit en, bit cv, video_timing_t c);
    bit was_run, last, accept;
    was_run = m_run;
    last    = m_run && (mx == m_act.ht - 1) && (my == m_act.vt - 1);
    accept  = cv && m_ready;
    if (m_run) begin
      if (mx == m_act.ht - 1) begin
        mx = 0;
        if (my == m_act.vt - 1) begin
          my = 0;
          m_run = en;
        end else begin
          my++;
        end
      end else begin
        mx++;
      end
    end else begin
      m_run = en; mx = 0; my = 0;
    end
    m_applied = 1'b0;
    m_error   = 1'b0;
    if (m_pendv) begin
      if (m_pend.ht < 16 || m_pend.vt < 16) begin
        m_pendv = 1'b0; m_error = 1'b1;
      end else if (!was_run || last) begin
        m_act = m_pend; m_pendv = 1'b0; m_applied = 1'b1;
      end
    end
    if (accept) begin
      m_pend = to_m(c); m_pendv = 1'b1;
    end
    m_ready = !m_pendv;
  endtask

  function automatic obs_t m_expect();
    obs_t o;
    o.x       = H_W'(mx);
    o.y       = V_W'(my);
    o.vs      = m_run && mx == 0 && my == 0;
    o.hs      = m_run && mx == m_act.hs;
    o.de      = m_run && mx >= m_act.hds && mx < m_act.hde && my >= m_act.vds && my < m_act.vde;
    o.skip    = 1'b0;
    o.ready   = m_ready;
    o.applied = m_applied;
    o.error   = m_error;
    return o;
  endfunction

  function automatic obs_t sample();
    return {x, y, video_de, video_hs, video_vs, video_skip, cfg_ready, cfg_applied, cfg_error};
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("x=%0d y=%0d de=%b hs=%b vs=%b skip=%b rdy=%b app=%b err=%b",
                     o.x, o.y, o.de, o.hs, o.vs, o.skip, o.ready, o.applied, o.error);
  endfunction

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic check(string name, obs_t act, obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %s, want %s", name, $time, fmt(act), fmt(exp));
      if (n_err >= MAX_FAILS) finish_run();
    end
  endtask

  task automatic bound_fail(string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait budget expired at %0t", name, $time);
  endtask

  // Drive one cycle of inputs and queue the expectation for the next edge.
  task automatic cycle(bit rst_v, bit en, bit cv, video_timing_t c);
    @(negedge video_rgb_clock);
    #1;
    reset_n   = rst_v;
    enable    = en;
    cfg_valid = cv;
    cfg       = c;
    if (rst_v) model_step(en, cv, c);
    else       model_reset();
    exp_q.push_back(m_expect());
  endtask

  task automatic run(int n, bit en);
    repeat (n) cycle(1'b1, en, 1'b0, rand_cfg());
  endtask

  task automatic send(bit en, video_timing_t c);
    int budget = 200;
    while (!m_ready && budget > 0) begin
      cycle(1'b1, en, 1'b0, rand_cfg());
      budget--;
    end
    if (budget == 0) bound_fail("cfg_ready_wait");
    cycle(1'b1, en, 1'b1, c);
  endtask

  // Assert reset mid-cycle; outputs must clear without a clock edge.
  task automatic pulse_reset(int hold, bit en);
    @(negedge video_rgb_clock);
    #1;
    reset_n   = 1'b0;
    enable    = en;
    cfg_valid = 1'b0;
    model_reset();
    #1;
    check("async_reset", sample(), m_expect());
    exp_q.push_back(m_expect());
    repeat (hold - 1) cycle(1'b0, en, 1'b0, rand_cfg());
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge video_rgb_clock);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pixel", sample(), e);
        if (!seen_de && video_de === 1'b1) begin
          seen_de = 1'b1;
          fde_x   = int'(x);
          fde_y   = int'(y);
        end
      end
    end
  end

  initial begin : driver
    int  budget;
    bit  en;
    video_timing_t c;

    model_reset();
    repeat (3) cycle(1'b0, 1'b0, 1'b0, rand_cfg());

    // Default timing from reset, through the first active line.
    budget = 30000;
    cycle(1'b1, 1'b1, 1'b0, rand_cfg());
    while (!(mx == 0 && my == 51) && budget > 0) begin
      cycle(1'b1, 1'b1, 1'b0, rand_cfg());
      budget--;
    end
    if (budget == 0) bound_fail("reach_line_51");
    n_cmp++;
    if (!(seen_de && fde_x == 50 && fde_y == 50)) begin
      n_err++;
      $display("FAIL first_de: got seen=%0b at (%0d,%0d), want (50,50)", seen_de, fde_x, fde_y);
    end

    // Wider raster offered mid-frame: must stay pending, then reset drops it.
    c = VT_DEFAULT;
    c.h_total = H_W'(600);
    send(1'b1, c);
    run(1100, 1'b1);
    pulse_reset(2, 1'b1);
    run(1100, 1'b1);
    pulse_reset(2, 1'b0);
    run(5, 1'b0);

    // Small raster applied while stopped, then a mid-frame swap.
    send(1'b0, mk(24, 4, 20, 2, 18, 3, 15));
    run(4, 1'b0);
    run(24 * 18 * 2 + 7, 1'b1);
    send(1'b1, mk(30, 5, 25, 0, 16, 2, 14));
    run(24 * 18 + 30 * 16 * 2, 1'b1);

    // Undersized rasters are discarded.
    send(1'b1, mk(32, 0, 32, 31, 8, 0, 8));
    run(5, 1'b1);
    send(1'b1, mk(15, 0, 15, 3, 20, 0, 20));
    run(5, 1'b1);
    send(1'b1, mk(20, 10, 5, 4, 16, 0, 16));
    run(30 * 16 + 5, 1'b1);

    // Accept coinciding with the last pixel of a frame.
    budget = 3000;
    while (!(m_run && m_ready && mx == m_act.ht - 1 && my == m_act.vt - 1) && budget > 0) begin
      cycle(1'b1, 1'b1, 1'b0, rand_cfg());
      budget--;
    end
    if (budget == 0) bound_fail("last_pixel_wait");
    cycle(1'b1, 1'b1, 1'b1, mk(20, 2, 18, 19, 17, 0, 17));
    run(20 * 17 * 3, 1'b1);

    // Enable dropped mid-frame: frame completes, then raster idles.
    budget = 3000;
    while (!(mx == 0 && my == 8) && budget > 0) begin
      cycle(1'b1, 1'b1, 1'b0, rand_cfg());
      budget--;
    end
    if (budget == 0) bound_fail("line_8_wait");
    budget = 3000;
    while (m_run && budget > 0) begin
      cycle(1'b1, 1'b0, 1'b0, rand_cfg());
      budget--;
    end
    if (budget == 0) bound_fail("stop_wait");
    run(10, 1'b0);

    // Randomized traffic: sticky enable, sporadic configs and resets.
    en = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 199) == 0) en = !en;
      if ($urandom_range(0, 3999) == 0) begin
        pulse_reset(1 + $urandom_range(0, 2), en);
      end else begin
        cycle(1'b1, en, ($urandom_range(0, 7) == 0), rand_cfg());
      end
    end

    @(negedge video_rgb_clock);
    #2;
    if (exp_q.size() != 0) bound_fail("queue_drain");
    finish_run();
  end

endmodule

// File: doc/video_timing_ctrl.md
VIDEO_TIMING_CTRL -- requirements
Module: video_timing_ctrl

Interface
REQ-001 SHALL have parameter H_W, default 10, horizontal counter/config width.
REQ-002 SHALL have parameter V_W, default 10, vertical counter/config width.
REQ-003 SHALL have port video_rgb_clock  in  1  pixel clock; sole clock.
REQ-004 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  in  1  run request for timing generation.
REQ-006 SHALL have port cfg_valid  in  1  new timing set offered.
REQ-007 SHALL have port cfg_ready  out  1  high when no config is pending.
REQ-008 SHALL have port cfg  in  video_timing_t  h_total, h_de_start, h_de_end, hs_pos (H_W each); v_total, v_de_start, v_de_end (V_W each).
REQ-009 SHALL have port x  out  H_W  current pixel column.
REQ-010 SHALL have port y  out  V_W  current line.
REQ-011 SHALL have ports video_de, video_hs, video_vs, video_skip  out  1 each  video strobes.
REQ-012 SHALL have port cfg_applied  out  1  one-cycle pulse when a pending config becomes active.
REQ-013 SHALL have port cfg_error  out  1  one-cycle pulse when an accepted config is discarded.

Function
REQ-014 SHALL implement states STOPPED and RUN: STOPPED->RUN when enable=1; RUN->STOPPED only on the last pixel of a frame (x=h_total-1, y=v_total-1) with enable=0.
REQ-015 In RUN, SHALL increment x each cycle, wrap x to 0 after h_total-1, increment y on that wrap, and wrap y to 0 after v_total-1.
REQ-016 In STOPPED, SHALL hold x=y=0 and drive all strobes 0; the first RUN cycle SHALL present x=0, y=0.
REQ-017 SHALL drive video_vs=1 for exactly one cycle, when x=0 and y=0 in RUN.
REQ-018 SHALL drive video_hs=1 for exactly one cycle per line, when x=hs_pos in RUN.
REQ-019 SHALL drive video_de=1 when h_de_start<=x<h_de_end and v_de_start<=y<v_de_end in RUN; start>=end on either axis SHALL yield no de.
REQ-020 SHALL tie video_skip to 0.
REQ-021 SHALL register all strobes so each is a function of the same-cycle x/y outputs, with 0 added latency from counter to strobe as seen at the ports.
REQ-022 SHALL accept cfg on a cycle where cfg_valid and cfg_ready are both 1, into a pending register, and drop cfg_ready on the next cycle.
REQ-023 SHALL apply the pending config on the last pixel of a frame, effective at the next x=0/y=0, or on the next cycle if in STOPPED.
REQ-024 SHALL pulse cfg_applied and raise cfg_ready in the cycle after the pending config is applied.
REQ-025 SHALL discard an accepted config with h_total<16 or v_total<16, pulse cfg_error, leave the active config unchanged, and raise cfg_ready on the next cycle.
REQ-026 When an accept and a frame end coincide, SHALL apply the new config at the following frame end, never mid-frame.
REQ-027 When enable falls mid-frame, SHALL complete the frame and then stop.
REQ-028 SHALL compare against active config registers only; cfg port changes without a handshake SHALL have no effect.

Reset
REQ-029 On reset_n=0, SHALL asynchronously force STOPPED, x=0, y=0, all strobes 0, cfg_applied=cfg_error=0, no pending config, and cfg_ready=0 until the first clock after release.
REQ-030 SHALL reset the active config to h_total=512, v_total=512, h_de 50..450, v_de 50..370, hs_pos=10.
REQ-031 Reset asserted mid-frame SHALL discard any pending config.

Structure
REQ-032 SHALL take the video_timing_t struct and the reset-default timing constant from pocket_pkg.
REQ-033 SHALL place the x/y counter with wrap logic in one sub-module, video_xy_counter.

Verification
REQ-034 Test: reset, enable=1 -> vs at cycle 0; hs at x=10 once per line; de first at (50,50); 400x320 de pixels per 512x512 frame.
REQ-035 Test: mid-frame cfg h_total=600 -> cfg_ready low, current frame still 512 wide; cfg_applied pulses; next frame 600 wide.
REQ-036 Test: cfg with v_total=8 -> cfg_error pulses once, timing unchanged, cfg_ready high next cycle.
REQ-037 Test: enable dropped at y=100 -> frame completes to (511,511), then x=y=0 and strobes 0.
REQ-038 Test: cfg accepted on the last-pixel cycle -> new config applied only at the following frame end.
REQ-039 Test: reset_n pulsed mid-frame with a config pending -> outputs 0 immediately, pending config lost, default timing resumes.
